// File: rtl/transfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : transfer_pkg
//  Purpose  : Shared packet layout, state encoding and helpers for the
//             key-value transfer link (transmit and receive sides).
//  Revision : 1.0
// ============================================================================
package transfer_pkg;

   // Packet geometry: three big-endian 32-bit fields, 12 bytes total.
   localparam int unsigned PKT_BYTES = 12;
   localparam int unsigned PKT_W     = PKT_BYTES * 8;

   // Byte offset of each field inside the packet.
   localparam int unsigned OFF_FROM  = 0;
   localparam int unsigned OFF_TO    = 4;
   localparam int unsigned OFF_AMT   = 8;

   // Byte value carried by preamble toggles (discarded by the receiver).
   localparam logic [7:0]  PRE_BYTE  = 8'h00;

   // Transmitter sequencing states.
   typedef enum logic [1:0] {
      ST_PRE  = 2'd0,
      ST_IDLE = 2'd1,
      ST_SEND = 2'd2
   } state_e;

   // Lays the three fields out so that byte 0 sits in the top 8 bits.
   function automatic logic [PKT_W-1:0] pack_pkt(
      input logic [31:0] from_key,
      input logic [31:0] to_key,
      input logic [31:0] amount
   );
      logic [PKT_W-1:0] pkt;
      pkt = '0;
      pkt[PKT_W-1-OFF_FROM*8 -: 32] = from_key;
      pkt[PKT_W-1-OFF_TO*8   -: 32] = to_key;
      pkt[PKT_W-1-OFF_AMT*8  -: 32] = amount;
      return pkt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/transfer_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : transfer_pacer
//  Purpose  : Byte-gap counter. Counts cycles since the last strobe toggle
//             and saturates once BYTE_GAP-1 is reached, flagging gap_ok_o.
//  Revision : 1.0
// ============================================================================
module transfer_pacer #(
   parameter int unsigned BYTE_GAP = 4
) (
   input  logic tick_in,
   input  logic rst_n,
   input  logic fire_i,
   output logic gap_ok_o
);

   localparam logic [7:0] GAP_LAST = 8'(BYTE_GAP - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Counter stops at GAP_LAST, so equality is enough to mean "elapsed".
   assign gap_ok_o = (cnt_q == GAP_LAST);

   // Restart on every toggle, otherwise count up until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (fire_i) begin
         cnt_d = 8'd0;
      end else if (!gap_ok_o) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge tick_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/transfer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : transfer_tx
//  Purpose  : Transfer-request serializer. Sends a preamble after reset,
//             then emits each accepted request as a 12-byte packet on the
//             byte/toggle-strobe link with a fixed minimum byte spacing.
//  Revision : 1.0
// ============================================================================
module transfer_tx #(
   parameter int unsigned BYTE_GAP = 4,
   parameter int unsigned PREAMBLE = 2
) (
   input  logic        tick_in,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] from_key,
   input  logic [31:0] to_key,
   input  logic [31:0] amount,
   output logic [7:0]  byte_out,
   output logic        newbyt,
   output logic        busy,
   output logic [15:0] pkt_count
);
   import transfer_pkg::*;

   localparam logic [3:0] LAST_BYTE = 4'(PKT_BYTES - 1);
   localparam logic [3:0] LAST_PRE  = 4'(PREAMBLE - 1);
   localparam bit         HAS_PRE   = (PREAMBLE != 0);

   state_e           state_q, state_d;
   logic             pend_full_q, pend_full_d;
   logic [PKT_W-1:0] pend_q, pend_d;
   logic [PKT_W-1:0] shift_q, shift_d;
   logic [3:0]       bcnt_q, bcnt_d;
   logic [3:0]       pcnt_q, pcnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             tog_q, tog_d;
   logic [15:0]      pkt_q, pkt_d;
   logic             fire;
   logic             gap_ok;
   logic             accept;

   transfer_pacer #(
      .BYTE_GAP (BYTE_GAP)
   ) u_pacer (
      .tick_in  (tick_in),
      .rst_n    (rst_n),
      .fire_i   (fire),
      .gap_ok_o (gap_ok)
   );

   assign req_ready = !pend_full_q && (state_q != ST_PRE);
   assign accept    = req_valid && req_ready;
   assign byte_out  = byte_q;
   assign newbyt    = tog_q;
   assign pkt_count = pkt_q;
   assign busy      = (state_q == ST_PRE) || pend_full_q || (state_q == ST_SEND);

   // Next-state logic: request capture, preamble, packet load and byte emission.
   always_comb begin
      state_d     = state_q;
      pend_full_d = pend_full_q;
      pend_d      = pend_q;
      shift_d     = shift_q;
      bcnt_d      = bcnt_q;
      pcnt_d      = pcnt_q;
      byte_d      = byte_q;
      pkt_d       = pkt_q;
      fire        = 1'b0;

      // Capture never collides with a load: ready is low while pending is full.
      if (accept) begin
         pend_d      = pack_pkt(from_key, to_key, amount);
         pend_full_d = 1'b1;
      end

      case (state_q)
         ST_PRE: begin
            if (!HAS_PRE) begin
               state_d = ST_IDLE;
            end else if (gap_ok) begin
               fire   = 1'b1;
               byte_d = PRE_BYTE;
               pcnt_d = pcnt_q + 4'd1;
               if (pcnt_q == LAST_PRE) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            // Load and emit byte 0 on the same edge so an accepted request
            // with the gap already elapsed starts on the very next edge.
            if (pend_full_q && gap_ok) begin
               fire        = 1'b1;
               byte_d      = pend_q[PKT_W-1 -: 8];
               shift_d     = pend_q << 8;
               bcnt_d      = 4'd1;
               pend_full_d = 1'b0;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (gap_ok) begin
               fire    = 1'b1;
               byte_d  = shift_q[PKT_W-1 -: 8];
               shift_d = shift_q << 8;
               if (bcnt_q == LAST_BYTE) begin
                  pkt_d  = pkt_q + 16'd1;
                  bcnt_d = 4'd0;
                  // Chain straight into the next packet to avoid an idle gap.
                  if (pend_full_q) begin
                     shift_d     = pend_q;
                     pend_full_d = 1'b0;
                  end else begin
                     shift_d = '0;
                     state_d = ST_IDLE;
                  end
               end else begin
                  bcnt_d = bcnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_PRE;
         end
      endcase

      tog_d = tog_q ^ fire;
   end

   // State and datapath registers; reset drops any partial or pending packet.
   always_ff @(posedge tick_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PRE;
         pend_full_q <= 1'b0;
         pend_q      <= '0;
         shift_q     <= '0;
         bcnt_q      <= 4'd0;
         pcnt_q      <= 4'd0;
         byte_q      <= PRE_BYTE;
         tog_q       <= 1'b0;
         pkt_q       <= 16'd0;
      end else begin
         state_q     <= state_d;
         pend_full_q <= pend_full_d;
         pend_q      <= pend_d;
         shift_q     <= shift_d;
         bcnt_q      <= bcnt_d;
         pcnt_q      <= pcnt_d;
         byte_q      <= byte_d;
         tog_q       <= tog_d;
         pkt_q       <= pkt_d;
      end
   end

endmodule
`default_nettype wire
